dram_addr_demux: RTL and testbench
==================================

# dram_addr_demux

Receiving end of the multiplexed DRAM address bus driven by the quad 2-input address multiplexers. It samples the shared row/column address lines under nRAS/nCAS control and rebuilds the full word address. It classifies each memory cycle as read, write, RAS-only refresh or CAS-before-RAS refresh, and emits one-clock strobes. It serves as the memory-side model/decoder for bench and emulation builds of the ULA memory subsystem.

## Interface
- AW, 7, width of the multiplexed address bus; full address is 2*AW bits.
- CLK  in  1  system clock; all inputs sampled on rising edge.
- nRES  in  1  asynchronous active-low reset.
- MA  in  AW  multiplexed address bus (row while nRAS falls, column while nCAS falls).
- nRAS  in  1  row address strobe, active low.
- nCAS  in  1  column address strobe, active low.
- nWE  in  1  write enable, active low; sampled on the CAS falling-edge clock.
- ROW  out  AW  latched row address.
- COL  out  AW  latched column address.
- ADDR  out  2*AW  {ROW, COL}, updated on each access.
- RD_STB  out  1  one-clock pulse: read access decoded.
- WR_STB  out  1  one-clock pulse: write access decoded.
- PAGE  out  1  high with RD_STB/WR_STB when the access is the 2nd or later CAS within one RAS-low period.
- REF_STB  out  1  one-clock pulse: refresh cycle completed.
- REF_ROW  out  AW  row refreshed; valid with REF_STB.
- ERR  out  1  one-clock pulse: protocol violation.

## Operation
- Edge detection: nRAS/nCAS are registered each clock (ras_q, cas_q). A falling edge is current=0 and _q=1; a rising edge is current=1 and _q=0. There is no extra synchronizer; inputs are synchronous to CLK.
- Arming: after reset, no edge is recognized until nRAS has been sampled high once. ras_q and cas_q reset to 1.
- States:
  - IDLE: nRAS high.
  - ROWOPEN: row latched, CAS high.
  - ACCESS: CAS low within the row.
  - CBR: CAS-before-RAS refresh in progress.
- IDLE, RAS fall with nCAS=1: ROW<=MA, clear the "accessed" flag and the page count, go to ROWOPEN.
- IDLE, RAS fall with nCAS sampled low (and cas_q low): CBR refresh.
  - REF_STB=1, REF_ROW=refresh counter.
  - Counter increments mod 2^AW; go to CBR.
- IDLE, CAS edges alone: ignored.
- ROWOPEN, CAS fall: COL<=MA, ADDR<={ROW,MA}.
  - RD_STB=1 if nWE=1, WR_STB=1 if nWE=0.
  - PAGE=1 if accessed flag already set; then set accessed; go to ACCESS.
- ACCESS, CAS rise: go to ROWOPEN.
- ACCESS or ROWOPEN, RAS rise: go to IDLE.
  - If accessed flag is clear: RAS-only refresh, REF_STB=1, REF_ROW=ROW.
- CBR: CAS edges ignored. RAS rise returns to IDLE with no strobe.
- Simultaneous events:
  - RAS and CAS fall on the same clock in IDLE: treat as a RAS fall with nCAS=1 (row latched, ROWOPEN), no access, ERR=1. An access then requires a fresh CAS fall.
  - RAS rise and CAS fall on the same clock in ROWOPEN: RAS wins. No access; RAS-only refresh strobe issued if no prior access.
  - RAS rise while in ACCESS (CAS still low): normal close; no ERR.
- Invariant: RD_STB, WR_STB and REF_STB are mutually exclusive on any clock.
- Refresh counter is AW bits, wraps 2^AW-1 -> 0, and only advances on CBR.

## Timing
- All outputs are registered. Reset values: ROW=0, COL=0, ADDR=0, RD_STB=0, WR_STB=0, PAGE=0, REF_STB=0, REF_ROW=0, ERR=0, counter=0, state IDLE, disarmed.
- Latency: input sampled at edge n produces the output change visible after edge n (one-clock latency from sample to strobe/latch).
- Strobes are exactly one clock wide; ROW/COL/ADDR/REF_ROW hold until the next update.
- Asynchronous reset mid-cycle clears immediately. A subsequent nRAS held low produces no row latch until nRAS goes high, then falls.

## Test plan
- Read: reset, nRAS high 2 clocks, MA=0x55, nRAS low, then MA=0x2A, nWE=1, nCAS low -> ROW=0x55, COL=0x2A, ADDR=0x2AAA, RD_STB one clock, PAGE=0.
- Page-mode write: same row 0x55, CAS cycles with MA=0x01 then 0x02, nWE=0 -> two WR_STB pulses; ADDR 0x2A81 (PAGE=0) then 0x2A82 (PAGE=1).
- RAS-only refresh: MA=0x33, nRAS low 3 clocks, nCAS high throughout, nRAS high -> REF_STB one clock after rise, REF_ROW=0x33, no RD/WR strobe.
- CBR wrap: 129 CBR cycles from reset -> REF_ROW sequence 0,1,...,127,0; ROW unchanged; CAS activity within CBR gives no strobes.
- Simultaneous RAS+CAS fall with MA=0x10 -> ERR one clock, ROW=0x10, no RD/WR; a subsequent CAS rise/fall with MA=0x05 -> RD_STB, ADDR=0x805.
- Reset mid-access: assert nRES while nRAS/nCAS low -> all outputs 0 at once; release with nRAS still low -> no strobes until nRAS high then low.

Source files
------------

// File: rtl/dram_addr_demux.sv
// rtl/dram_addr_demux.sv - memory-side decoder for a row/column multiplexed DRAM address bus
//
// Rebuilds the full word address from the shared MA lines under nRAS/nCAS control.
// Each memory cycle is classified as read, write, RAS-only refresh or CAS-before-RAS
// refresh, and a one-clock strobe is issued for it. Every output is registered.
//
// Ports:
//   CLK      in   system clock, all inputs sampled on the rising edge
//   nRES     in   asynchronous active-low reset
//   MA       in   [AW]    multiplexed address (row at RAS fall, column at CAS fall)
//   nRAS     in   row address strobe, active low
//   nCAS     in   column address strobe, active low
//   nWE      in   write enable, active low, taken on the CAS-fall clock
//   ROW      out  [AW]    latched row address
//   COL      out  [AW]    latched column address
//   ADDR     out  [2*AW]  {ROW, COL} of the most recent access
//   RD_STB   out  one-clock read access pulse
//   WR_STB   out  one-clock write access pulse
//   PAGE     out  with RD/WR_STB: 2nd or later CAS in the same RAS-low period
//   REF_STB  out  one-clock refresh-complete pulse
//   REF_ROW  out  [AW]    refreshed row, valid with REF_STB
//   ERR      out  one-clock protocol violation pulse

module dram_addr_demux #(
  parameter int AW = 7
) (
  input  logic            CLK,
  input  logic            nRES,
  input  logic [AW-1:0]   MA,
  input  logic            nRAS,
  input  logic            nCAS,
  input  logic            nWE,
  output logic [AW-1:0]   ROW,
  output logic [AW-1:0]   COL,
  output logic [2*AW-1:0] ADDR,
  output logic            RD_STB,
  output logic            WR_STB,
  output logic            PAGE,
  output logic            REF_STB,
  output logic [AW-1:0]   REF_ROW,
  output logic            ERR
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ROWOPEN = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_CBR     = 2'd3;

  logic [1:0]      state_q,   state_d;
  logic            ras_q,     ras_d;
  logic            cas_q,     cas_d;
  logic            armed_q,   armed_d;
  logic            accessed_q, accessed_d;
  logic [AW-1:0]   refcnt_q,  refcnt_d;
  logic [AW-1:0]   row_q,     row_d;
  logic [AW-1:0]   col_q,     col_d;
  logic [2*AW-1:0] addr_q,    addr_d;
  logic            rd_stb_q,  rd_stb_d;
  logic            wr_stb_q,  wr_stb_d;
  logic            page_q,    page_d;
  logic            ref_stb_q, ref_stb_d;
  logic [AW-1:0]   ref_row_q, ref_row_d;
  logic            err_q,     err_d;

  logic ras_fall, ras_rise, cas_fall, cas_rise;

  // Edges only count once nRAS has been seen high after reset; this keeps a
  // strobe held low across reset release from looking like a fresh fall.
  assign ras_fall = armed_q &  ras_q & ~nRAS;
  assign ras_rise = armed_q & ~ras_q &  nRAS;
  assign cas_fall = armed_q &  cas_q & ~nCAS;
  assign cas_rise = armed_q & ~cas_q &  nCAS;

  always_comb begin
    state_d    = state_q;
    ras_d      = nRAS;
    cas_d      = nCAS;
    armed_d    = armed_q | nRAS;
    accessed_d = accessed_q;
    refcnt_d   = refcnt_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    rd_stb_d   = 1'b0;
    wr_stb_d   = 1'b0;
    page_d     = 1'b0;
    ref_stb_d  = 1'b0;
    ref_row_d  = ref_row_q;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ras_fall) begin
          if (!nCAS && !cas_q) begin
            // CAS was already low before RAS fell: CAS-before-RAS refresh
            // using the internal row counter.
            ref_stb_d = 1'b1;
            ref_row_d = refcnt_q;
            refcnt_d  = refcnt_q + AW'(1);
            state_d   = ST_CBR;
          end else begin
            // A CAS falling on the same clock as RAS is flagged and not
            // treated as an access; a fresh CAS fall is needed afterwards.
            row_d      = MA;
            accessed_d = 1'b0;
            err_d      = ~nCAS;
            state_d    = ST_ROWOPEN;
          end
        end
      end

      ST_ROWOPEN: begin
        // RAS rise outranks a CAS fall on the same clock.
        if (ras_rise) begin
          if (!accessed_q) begin
            ref_stb_d = 1'b1;
            ref_row_d = row_q;
          end
          state_d = ST_IDLE;
        end else if (cas_fall) begin
          col_d      = MA;
          addr_d     = {row_q, MA};
          rd_stb_d   = nWE;
          wr_stb_d   = ~nWE;
          page_d     = accessed_q;
          accessed_d = 1'b1;
          state_d    = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (ras_rise) begin
          if (!accessed_q) begin
            ref_stb_d = 1'b1;
            ref_row_d = row_q;
          end
          state_d = ST_IDLE;
        end else if (cas_rise) begin
          state_d = ST_ROWOPEN;
        end
      end

      ST_CBR: begin
        if (ras_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_q    <= ST_IDLE;
      ras_q      <= 1'b1;
      cas_q      <= 1'b1;
      armed_q    <= 1'b0;
      accessed_q <= 1'b0;
      refcnt_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      page_q     <= 1'b0;
      ref_stb_q  <= 1'b0;
      ref_row_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ras_q      <= ras_d;
      cas_q      <= cas_d;
      armed_q    <= armed_d;
      accessed_q <= accessed_d;
      refcnt_q   <= refcnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      rd_stb_q   <= rd_stb_d;
      wr_stb_q   <= wr_stb_d;
      page_q     <= page_d;
      ref_stb_q  <= ref_stb_d;
      ref_row_q  <= ref_row_d;
      err_q      <= err_d;
    end
  end

  assign ROW     = row_q;
  assign COL     = col_q;
  assign ADDR    = addr_q;
  assign RD_STB  = rd_stb_q;
  assign WR_STB  = wr_stb_q;
  assign PAGE    = page_q;
  assign REF_STB = ref_stb_q;
  assign REF_ROW = ref_row_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_dram_addr_demux.sv
// tb/tb_dram_addr_demux.sv - self-checking bench for dram_addr_demux

module tb_dram_addr_demux;

  localparam int AW = 7;

  logic            CLK = 1'b0;
  logic            nRES;
  logic [AW-1:0]   MA;
  logic            nRAS, nCAS, nWE;
  logic [AW-1:0]   ROW, COL, REF_ROW;
  logic [2*AW-1:0] ADDR;
  logic            RD_STB, WR_STB, PAGE, REF_STB, ERR;

  dram_addr_demux #(.AW(AW)) dut (
    .CLK(CLK), .nRES(nRES), .MA(MA), .nRAS(nRAS), .nCAS(nCAS), .nWE(nWE),
    .ROW(ROW), .COL(COL), .ADDR(ADDR), .RD_STB(RD_STB), .WR_STB(WR_STB),
    .PAGE(PAGE), .REF_STB(REF_STB), .REF_ROW(REF_ROW), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the memory cycle from the strobe sequence alone.
  // mode: 0 = no row open, 1 = row open / CAS high, 2 = CAS low in row, 3 = CBR.
  int m_mode, m_cnt, e_row, e_col, e_addr, e_ref_row;
  bit m_armed, m_pras, m_pcas, m_acc;
  bit e_rd, e_wr, e_page, e_ref, e_err;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_armed = 0; m_pras = 1; m_pcas = 1; m_acc = 0;
    e_row = 0; e_col = 0; e_addr = 0; e_ref_row = 0;
    e_rd = 0; e_wr = 0; e_page = 0; e_ref = 0; e_err = 0;
  endtask

  task automatic model_step();
    bit fr, rr, fc, rc;
    fr = m_armed &&  m_pras && !nRAS;
    rr = m_armed && !m_pras &&  nRAS;
    fc = m_armed &&  m_pcas && !nCAS;
    rc = m_armed && !m_pcas &&  nCAS;
    e_rd = 0; e_wr = 0; e_page = 0; e_ref = 0; e_err = 0;
    if (m_mode == 0 && fr) begin
      if (!nCAS && !m_pcas) begin
        e_ref = 1; e_ref_row = m_cnt; m_cnt = (m_cnt + 1) % (1 << AW); m_mode = 3;
      end else begin
        e_row = int'(MA); m_acc = 0; e_err = !nCAS; m_mode = 1;
      end
    end else if ((m_mode == 1 || m_mode == 2) && rr) begin
      if (!m_acc) begin e_ref = 1; e_ref_row = e_row; end
      m_mode = 0;
    end else if (m_mode == 1 && fc) begin
      e_col = int'(MA); e_addr = e_row * (1 << AW) + int'(MA);
      e_rd = nWE; e_wr = !nWE; e_page = m_acc; m_acc = 1; m_mode = 2;
    end else if (m_mode == 2 && rc) begin
      m_mode = 1;
    end else if (m_mode == 3 && rr) begin
      m_mode = 0;
    end
    if (nRAS) m_armed = 1;
    m_pras = nRAS;
    m_pcas = nCAS;
  endtask

  function automatic logic [63:0] obs_vec();
    return {24'd0, ROW, COL, ADDR, RD_STB, WR_STB, PAGE, REF_STB, REF_ROW, ERR};
  endfunction

  function automatic logic [63:0] exp_vec();
    logic [AW-1:0] r, c, rr;
    logic [2*AW-1:0] a;
    r = AW'(e_row); c = AW'(e_col); rr = AW'(e_ref_row); a = (2*AW)'(e_addr);
    return {24'd0, r, c, a, e_rd, e_wr, e_page, e_ref, rr, e_err};
  endfunction

  // Inputs change on the falling edge; outputs compared on the next falling edge.
  task automatic drive(input bit ras, input bit cas, input bit we, input logic [AW-1:0] ma);
    nRAS = ras; nCAS = cas; nWE = we; MA = ma;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    chk("cycle", obs_vec(), exp_vec());
    chk("strobe_mutex", 64'(RD_STB + WR_STB + REF_STB > 1), 64'd0);
  endtask

  initial begin
    nRES = 1'b0; nRAS = 1'b1; nCAS = 1'b1; nWE = 1'b1; MA = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset_outputs", obs_vec(), 64'd0);
    nRES = 1'b1;

    // Read
    drive(1, 1, 1, 7'h00);
    drive(1, 1, 1, 7'h00);
    drive(0, 1, 1, 7'h55);
    chk("read_row", 64'(ROW), 64'h55);
    drive(0, 0, 1, 7'h2A);
    chk("read_rd_stb", 64'({RD_STB, WR_STB, PAGE}), 64'b100);
    chk("read_addr", 64'(ADDR), 64'h2AAA);
    chk("read_col", 64'(COL), 64'h2A);
    drive(0, 0, 1, 7'h2A);
    chk("read_stb_width", 64'(RD_STB), 64'd0);
    drive(0, 1, 1, 7'h00);
    drive(1, 1, 1, 7'h00);
    chk("read_close_no_ref", 64'(REF_STB), 64'd0);

    // Page-mode write
    drive(0, 1, 0, 7'h55);
    drive(0, 0, 0, 7'h01);
    chk("page_wr1", 64'({WR_STB, PAGE, ADDR}), {48'd0, 2'b10, 14'h2A81});
    drive(0, 1, 0, 7'h01);
    drive(0, 0, 0, 7'h02);
    chk("page_wr2", 64'({WR_STB, PAGE, ADDR}), {48'd0, 2'b11, 14'h2A82});
    drive(0, 1, 1, 7'h00);
    drive(1, 1, 1, 7'h00);

    // RAS-only refresh
    drive(0, 1, 1, 7'h33);
    drive(0, 1, 1, 7'h33);
    drive(0, 1, 1, 7'h33);
    drive(1, 1, 1, 7'h00);
    chk("ras_only_ref", 64'({REF_STB, RD_STB, WR_STB, REF_ROW}), {54'd0, 3'b100, 7'h33});
    drive(1, 1, 1, 7'h00);
    chk("ras_only_width", 64'(REF_STB), 64'd0);

    // Simultaneous RAS+CAS fall, then a fresh CAS fall
    drive(0, 0, 1, 7'h10);
    chk("simul_err", 64'({ERR, RD_STB, WR_STB, ROW}), {54'd0, 3'b100, 7'h10});
    drive(0, 1, 1, 7'h05);
    drive(0, 0, 1, 7'h05);
    chk("simul_then_rd", 64'({RD_STB, ADDR}), {49'd0, 1'b1, 14'h0805});
    drive(1, 1, 1, 7'h00);

    // CBR refresh with wrap; stray CAS activity inside CBR
    for (int i = 0; i < 129; i++) begin
      drive(1, 0, 1, 7'($urandom));
      drive(0, 0, 1, 7'($urandom));
      chk("cbr_ref_row", 64'({REF_STB, REF_ROW}), 64'({1'b1, 7'(i % 128)}));
      drive(0, 1, 0, 7'($urandom));
      drive(0, 0, 0, 7'($urandom));
      drive(1, 1, 1, 7'h00);
    end
    chk("cbr_row_kept", 64'(ROW), 64'h10);

    // Asynchronous reset in the middle of an access
    drive(0, 1, 1, 7'h22);
    drive(0, 0, 1, 7'h11);
    #2 nRES = 1'b0;
    #1 chk("async_reset", obs_vec(), 64'd0);
    model_reset();
    @(negedge CLK);
    nRES = 1'b1;
    drive(0, 0, 1, 7'h44);
    drive(0, 1, 1, 7'h44);
    drive(0, 0, 1, 7'h44);
    chk("post_reset_quiet", 64'({ROW, RD_STB, WR_STB, REF_STB}), 64'd0);
    drive(1, 1, 1, 7'h00);
    drive(0, 1, 1, 7'h44);
    chk("post_reset_rearm", 64'(ROW), 64'h44);
    drive(1, 1, 1, 7'h00);

    // Randomized traffic: strobes mostly hold, occasionally toggle
    for (int i = 0; i < 4000; i++) begin
      bit r, c;
      r = ($urandom_range(0, 3) == 0) ? ~nRAS : nRAS;
      c = ($urandom_range(0, 2) == 0) ? ~nCAS : nCAS;
      drive(r, c, 1'($urandom), 7'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
